placar_pontos: RTL and testbench
================================

Name: placar_pontos

Overview:
- Score accumulator and game-phase controller for the rhythm game.
- Consumes single-cycle hit/miss pulses from the note-judging logic and produces the 7-bit score (pontos) and display enable consumed by display_pontos.
- Also tracks hit streak, a session high score (recorde), and blanks or blinks the display according to game phase.

Parameters:
- MAX_PONTOS, 99, saturation ceiling for pontos and recorde (must be ≤127).
- COMBO_LEN, 4, consecutive hits needed before each hit scores double.
- PENALIDADE, 1, points subtracted per miss (saturates at 0).
- BLINK_DIV, 25_000_000, clk cycles per enable toggle in FIM state.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state, including recorde.
- start  in  1  pulse; begins a new game.
- acerto  in  1  pulse; note hit.
- erro  in  1  pulse; note missed.
- fim  in  1  pulse; song finished.
- pontos  out  7  current score, registered, to display_pontos.pontos.
- enable  out  1  display enable, registered, to display_pontos.enable.
- recorde  out  7  best score since reset, registered.
- combo  out  3  current streak, saturating at 7.
- game_over  out  1  high while in FIM.

Behaviour:
- Reset values: pontos=0, recorde=0, combo=0, enable=0, game_over=0, state=OCIOSO, blink counter=0. Reset has priority over every other input.
- States: OCIOSO, JOGANDO, FIM. Encoding is 2 bits.
- OCIOSO: enable=0 (display blank). start -> JOGANDO, clearing pontos, combo and the blink counter in the same edge. acerto, erro and fim are ignored.
- JOGANDO: enable=1.
  - acerto alone: streak is incremented first (combo_next = min(combo+1,7)). If combo_next ≥ COMBO_LEN, pontos += 2; otherwise pontos += 1. The result saturates at MAX_PONTOS.
  - erro alone: combo=0; pontos = max(pontos−PENALIDADE, 0).
  - acerto and erro in the same cycle: treated as erro only.
  - fim: -> FIM. fim has priority over acerto/erro in the same cycle, so the score is frozen at its pre-edge value. On the same edge, recorde = max(recorde, pontos).
  - start: restarts the game (pontos=0, combo=0, stay in JOGANDO). start has priority over fim/acerto/erro.
- FIM: game_over=1; pontos is held.
  - enable toggles every BLINK_DIV cycles. The first toggle (to 0) comes BLINK_DIV cycles after entry, and enable=1 on the cycle of entry.
  - start -> JOGANDO (clears as above, enable=1 next cycle).
  - acerto, erro and fim are ignored.
- Latency: every output reflects an input pulse one clk edge later. No combinational path from inputs to outputs.
- Arithmetic:
  - Compute in 8 bits internally to avoid wrap before saturation.
  - The decrement is compared before subtracting (no underflow).
  - The blink counter is width $clog2(BLINK_DIV) and wraps to 0 on each toggle.
- Held pulses: inputs are not edge-detected. A pulse held N cycles counts N times; upstream guarantees one-cycle pulses.
- Reset mid-game: returns to OCIOSO with recorde cleared.

Decomposition:
- Shared package pontos_pkg:
  - state enum (OCIOSO/JOGANDO/FIM)
  - PONTOS_W=7
  - default MAX_PONTOS
- One natural sub-module, blink_div: a parameterised divider with clear and toggle output, also reusable by other blinking indicators.
- The scoring datapath stays in placar_pontos.

Test Plan:
1. Reset, then start, then 3 acerto pulses -> pontos=3, combo=3, enable=1, game_over=0; before start, enable=0 and pontos=0.
2. start, then 6 acerto pulses (COMBO_LEN=4) -> pontos 1,2,3,5,7,9; combo=6. Next erro -> pontos=8, combo=0.
3. Saturation: with pontos=98 and combo≥4, acerto -> pontos=99, and a further acerto stays 99. With pontos=0, erro -> 0.
4. acerto and erro in the same cycle at pontos=5, combo=2 -> pontos=4, combo=0. fim and acerto in the same cycle -> pontos unchanged, game_over=1.
5. Game ends at 42 then a new game ends at 30 -> recorde 42 after both games. A third game ending at 50 -> recorde=50. reset -> recorde=0.
6. FIM blink with BLINK_DIV=4 -> enable reads 1,1,1,1,0,0,0,0,1 from the entry edge. start during FIM -> JOGANDO, pontos=0, enable=1 on the next cycle.

Source files
------------

// File: rtl/pontos_pkg.sv
// Shared types and constants for the rhythm-game score block.
package pontos_pkg;

    localparam int PONTOS_W       = 7;
    localparam int MAX_PONTOS_DEF = 99;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

endpackage

// File: rtl/blink_div.sv
// Free-running divider: pulses tgl for one cycle every DIV enabled cycles.
// clr restarts the count from zero and wins over en.
module blink_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tgl
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tgl   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tgl   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/placar_pontos.sv
// Score accumulator and game-phase controller: hit/miss pulses in, registered
// score, high score, streak and display enable out (one edge of latency).
module placar_pontos
    import pontos_pkg::*;
#(
    parameter int MAX_PONTOS = MAX_PONTOS_DEF,
    parameter int COMBO_LEN  = 4,
    parameter int PENALIDADE = 1,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                acerto,
    input  logic                erro,
    input  logic                fim,
    output logic [PONTOS_W-1:0] pontos,
    output logic                enable,
    output logic [PONTOS_W-1:0] recorde,
    output logic [2:0]          combo,
    output logic                game_over
);

    localparam logic [7:0]          MAX8   = 8'(MAX_PONTOS);
    localparam logic [PONTOS_W-1:0] MAX_P  = PONTOS_W'(MAX_PONTOS);
    localparam logic [7:0]          PEN8   = 8'(PENALIDADE);
    localparam logic [3:0]          COMBO4 = 4'(COMBO_LEN);

    estado_t             state_q, state_d;
    logic [PONTOS_W-1:0] pontos_q, pontos_d;
    logic [PONTOS_W-1:0] recorde_q, recorde_d;
    logic [2:0]          combo_q, combo_d;
    logic                enable_q, enable_d;
    logic                game_over_q, game_over_d;

    logic                blink_clr, blink_en, blink_tgl;
    logic [2:0]          combo_inc;
    logic [7:0]          pontos8, soma;
    logic [PONTOS_W-1:0] soma_sat, sub_sat, recorde_max;

    blink_div #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .reset (reset),
        .clr   (blink_clr),
        .en    (blink_en),
        .tgl   (blink_tgl)
    );

    // Streak is bumped before deciding whether this hit scores double.
    always_comb begin
        combo_inc   = (combo_q == 3'd7) ? 3'd7 : combo_q + 3'd1;
        pontos8     = {1'b0, pontos_q};
        soma        = pontos8 + (({1'b0, combo_inc} >= COMBO4) ? 8'd2 : 8'd1);
        soma_sat    = (soma > MAX8) ? MAX_P : soma[PONTOS_W-1:0];
        sub_sat     = (pontos8 >= PEN8) ? PONTOS_W'(pontos8 - PEN8) : '0;
        recorde_max = (pontos_q > recorde_q) ? pontos_q : recorde_q;
    end

    always_comb begin
        state_d   = state_q;
        pontos_d  = pontos_q;
        recorde_d = recorde_q;
        combo_d   = combo_q;
        enable_d  = enable_q;
        blink_clr = 1'b0;
        blink_en  = 1'b0;

        case (state_q)
            OCIOSO: begin
                enable_d = 1'b0;
                if (start) begin
                    state_d   = JOGANDO;
                    pontos_d  = '0;
                    combo_d   = '0;
                    enable_d  = 1'b1;
                    blink_clr = 1'b1;
                end
            end
            JOGANDO: begin
                enable_d = 1'b1;
                if (start) begin
                    pontos_d  = '0;
                    combo_d   = '0;
                    blink_clr = 1'b1;
                end else if (fim) begin
                    state_d   = FIM;
                    recorde_d = recorde_max;
                    blink_clr = 1'b1;
                end else if (erro) begin
                    combo_d  = '0;
                    pontos_d = sub_sat;
                end else if (acerto) begin
                    combo_d  = combo_inc;
                    pontos_d = soma_sat;
                end
            end
            FIM: begin
                blink_en = 1'b1;
                if (blink_tgl) enable_d = ~enable_q;
                if (start) begin
                    state_d   = JOGANDO;
                    pontos_d  = '0;
                    combo_d   = '0;
                    enable_d  = 1'b1;
                    blink_clr = 1'b1;
                end
            end
            default: begin
                state_d  = OCIOSO;
                enable_d = 1'b0;
            end
        endcase

        game_over_d = (state_d == FIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OCIOSO;
            pontos_q    <= '0;
            recorde_q   <= '0;
            combo_q     <= '0;
            enable_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pontos_q    <= pontos_d;
            recorde_q   <= recorde_d;
            combo_q     <= combo_d;
            enable_q    <= enable_d;
            game_over_q <= game_over_d;
        end
    end

    assign pontos    = pontos_q;
    assign recorde   = recorde_q;
    assign combo     = combo_q;
    assign enable    = enable_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_placar_pontos.sv
// Directed-vector bench for placar_pontos with a short blink period.
module tb_placar_pontos;

    logic       clk = 1'b0;
    logic       reset, start, acerto, erro, fim;
    logic [6:0] pontos, recorde;
    logic [2:0] combo;
    logic       enable, game_over;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    placar_pontos #(.BLINK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .acerto    (acerto),
        .erro      (erro),
        .fim       (fim),
        .pontos    (pontos),
        .enable    (enable),
        .recorde   (recorde),
        .combo     (combo),
        .game_over (game_over)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one single-cycle pulse pattern; outputs are settled on return.
    task automatic step(input logic s, input logic a, input logic e, input logic f);
        @(negedge clk);
        start = s; acerto = a; erro = e; fim = f;
        @(negedge clk);
        start = 1'b0; acerto = 1'b0; erro = 1'b0; fim = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Each hit,hit,miss triple nets +1 and never reaches the double-score streak.
    task automatic play_game(input int n);
        step(1, 0, 0, 0);
        repeat (n) begin
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
            step(0, 0, 1, 0);
        end
        step(0, 0, 0, 1);
    endtask

    logic [8:0] blink_exp;
    logic [6:0] seq_exp [6];

    initial begin
        reset = 1'b1; start = 1'b0; acerto = 1'b0; erro = 1'b0; fim = 1'b0;
        do_reset();
        check("rst_pontos", pontos, 0);
        check("rst_recorde", recorde, 0);
        check("rst_combo", combo, 0);
        check("rst_enable", enable, 0);
        check("rst_game_over", game_over, 0);

        // Idle ignores hits; then a short game.
        step(0, 1, 0, 0);
        check("idle_pontos", pontos, 0);
        check("idle_enable", enable, 0);
        step(1, 0, 0, 0);
        check("start_enable", enable, 1);
        repeat (3) step(0, 1, 0, 0);
        check("t1_pontos", pontos, 3);
        check("t1_combo", combo, 3);
        check("t1_enable", enable, 1);
        check("t1_game_over", game_over, 0);

        // Streak doubling from the fourth hit.
        seq_exp = '{7'd1, 7'd2, 7'd3, 7'd5, 7'd7, 7'd9};
        step(1, 0, 0, 0);
        check("restart_pontos", pontos, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            check($sformatf("t2_hit%0d", i), pontos, seq_exp[i]);
        end
        check("t2_combo", combo, 6);
        step(0, 0, 1, 0);
        check("t2_erro_pontos", pontos, 8);
        check("t2_erro_combo", combo, 0);

        // Saturation: 3 hits (3), two misses (1), 4 hits (6), 46 doubles (98).
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        check("t3_pre_pontos", pontos, 1);
        repeat (50) step(0, 1, 0, 0);
        check("t3_98", pontos, 98);
        check("t3_combo_sat", combo, 7);
        step(0, 1, 0, 0);
        check("t3_sat99", pontos, 99);
        step(0, 1, 0, 0);
        check("t3_stay99", pontos, 99);
        repeat (99) step(0, 0, 1, 0);
        check("t3_zero", pontos, 0);
        step(0, 0, 1, 0);
        check("t3_floor", pontos, 0);

        // Simultaneous pulses: reach 5 with combo 2, then acerto+erro.
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        repeat (2) step(0, 0, 1, 0);
        repeat (2) step(0, 1, 0, 0);
        check("t4_pre_pontos", pontos, 5);
        check("t4_pre_combo", combo, 2);
        step(0, 1, 1, 0);
        check("t4_both_pontos", pontos, 4);
        check("t4_both_combo", combo, 0);

        // fim beats acerto; enable then blinks with period 4.
        blink_exp = 9'b100001111;
        step(0, 1, 0, 1);
        check("t4_fim_pontos", pontos, 4);
        check("t4_game_over", game_over, 1);
        check("t4_recorde", recorde, 4);
        check("blink0", enable, blink_exp[0]);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("blink%0d", i), enable, blink_exp[i]);
        end
        step(1, 0, 0, 0);
        check("t6_restart_pontos", pontos, 0);
        check("t6_restart_enable", enable, 1);
        check("t6_restart_game_over", game_over, 0);

        // High score across games.
        play_game(42);
        check("g1_pontos", pontos, 42);
        check("g1_recorde", recorde, 42);
        play_game(30);
        check("g2_pontos", pontos, 30);
        check("g2_recorde", recorde, 42);
        play_game(50);
        check("g3_recorde", recorde, 50);
        step(0, 0, 1, 0);
        check("fim_ignores_erro", pontos, 50);
        do_reset();
        check("rst2_recorde", recorde, 0);
        check("rst2_pontos", pontos, 0);
        check("rst2_enable", enable, 0);
        check("rst2_game_over", game_over, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
